// File: rtl/comp_pipe_compare_pkg.sv
// Shared ALU compare definitions: default widths and the {lt, eq, gt} flag bundle
// that the branch-resolve logic also uses.
package comp_pipe_compare_pkg;

  localparam int unsigned CMP_W_DEFAULT     = 64;
  localparam int unsigned CMP_TAG_W_DEFAULT = 5;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

  // gt is derived so that exactly one flag is ever set.
  function automatic cmp_flags_t cmp_flags_make(input logic lt, input logic eq);
    cmp_flags_t f;
    f.lt = lt;
    f.eq = eq;
    f.gt = ~lt & ~eq;
    return f;
  endfunction

endpackage

// File: rtl/comp_pipe_compare_if.sv
// Issue/writeback handshake bundle for the pipelined compare unit.
interface comp_pipe_compare_if
  import comp_pipe_compare_pkg::*;
#(
  parameter int unsigned W     = CMP_W_DEFAULT,
  parameter int unsigned TAG_W = CMP_TAG_W_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_ext;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic             out_lt;
  logic             out_eq;
  logic             out_gt;
  logic [W+1:0]     out_diff;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_ext, in_tag, out_ready,
    input  in_ready, out_valid, out_lt, out_eq, out_gt, out_diff, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ext, in_tag, out_ready,
    output in_ready, out_valid, out_lt, out_eq, out_gt, out_diff, out_tag
  );

endinterface

// File: rtl/comp_pipe_compare_extend_w.sv
// Widens an operand by one bit: sign-extends when ext_i is set, zero-extends otherwise.
module comp_extend_w
  import comp_pipe_compare_pkg::*;
#(
  parameter int unsigned W = CMP_W_DEFAULT
) (
  input  logic [W-1:0] din_i,
  input  logic         ext_i,
  output logic [W:0]   dout_o
);

  assign dout_o = {ext_i & din_i[W-1], din_i};

endmodule

// File: rtl/comp_pipe_compare.sv
// Two-stage pipelined magnitude comparator: S1 registers extended operands, S2 registers
// flags and difference. Valid/ready on both sides, two entries in flight, no skid buffer.
module comp_pipe_compare
  import comp_pipe_compare_pkg::*;
#(
  parameter int unsigned W     = CMP_W_DEFAULT,
  parameter int unsigned TAG_W = CMP_TAG_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  comp_pipe_compare_if.slave  bus
);

  logic [W:0] a_x;
  logic [W:0] b_x;

  comp_extend_w #(.W(W)) u_ext_a (
    .din_i  (bus.in_a),
    .ext_i  (bus.in_ext),
    .dout_o (a_x)
  );

  comp_extend_w #(.W(W)) u_ext_b (
    .din_i  (bus.in_b),
    .ext_i  (bus.in_ext),
    .dout_o (b_x)
  );

  // Stage registers
  logic             s1_valid_q, s1_valid_d;
  logic [W:0]       s1_a_q, s1_a_d;
  logic [W:0]       s1_b_q, s1_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  cmp_flags_t       s2_flags_q, s2_flags_d;
  logic [W+1:0]     s2_diff_q, s2_diff_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic             s2_adv;
  logic             s1_adv;
  logic             in_xfer;
  logic [W+1:0]     diff;
  logic             s1_eq;

  // in_ready is combinational from out_ready so a draining S2 frees both stages at once.
  always_comb begin
    s2_adv  = ~s2_valid_q | bus.out_ready;
    s1_adv  = ~s1_valid_q | s2_adv;
    in_xfer = bus.in_valid & s1_adv;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
    end
    if (in_xfer) begin
      s1_a_d   = a_x;
      s1_b_d   = b_x;
      s1_tag_d = bus.in_tag;
    end
  end

  // One extra sign bit on each side keeps the subtraction free of overflow.
  always_comb begin
    diff  = {s1_a_q[W], s1_a_q} - {s1_b_q[W], s1_b_q};
    s1_eq = (s1_a_q == s1_b_q);
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_flags_d = s2_flags_q;
    s2_diff_d  = s2_diff_q;
    s2_tag_d   = s2_tag_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_adv && s1_valid_q) begin
      s2_flags_d = cmp_flags_make(diff[W+1], s1_eq);
      s2_diff_d  = diff;
      s2_tag_d   = s1_tag_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_flags_q <= '0;
      s2_diff_q  <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_flags_q <= s2_flags_d;
      s2_diff_q  <= s2_diff_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_lt    = s2_flags_q.lt;
  assign bus.out_eq    = s2_flags_q.eq;
  assign bus.out_gt    = s2_flags_q.gt;
  assign bus.out_diff  = s2_diff_q;
  assign bus.out_tag   = s2_tag_q;

endmodule

// File: tb/tb_comp_pipe_compare.sv
// Directed W=64 checks followed by a randomized W=8 run against a queue-based model.
module tb_comp_pipe_compare;
  import comp_pipe_compare_pkg::*;

  typedef struct packed {
    logic        lt;
    logic        eq;
    logic        gt;
    logic [65:0] diff;
  } ref_t;

  typedef struct packed {
    ref_t        r;
    logic [2:0]  tag;
    logic [31:0] acc;
  } exp8_t;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  comp_pipe_compare_if #(.W(64), .TAG_W(5)) bus64 ();
  comp_pipe_compare_if #(.W(8),  .TAG_W(3)) bus8 ();

  comp_pipe_compare #(.W(64), .TAG_W(5)) u_dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus64)
  );

  comp_pipe_compare #(.W(8), .TAG_W(3)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operands taken as integers of width w, signed or unsigned; difference reduced mod 2^(w+2).
  function automatic ref_t ref_cmp(input logic [63:0] a, input logic [63:0] b,
                                   input logic ext, input int w);
    logic signed [67:0] va, vb, d, m;
    ref_t r;
    m  = 68'sd1 <<< w;
    va = $signed({4'b0, a});
    vb = $signed({4'b0, b});
    if (ext && a[w-1]) va = va - m;
    if (ext && b[w-1]) vb = vb - m;
    d      = (va - vb) & ((m <<< 2) - 68'sd1);
    r.lt   = (va < vb);
    r.eq   = (va == vb);
    r.gt   = (va > vb);
    r.diff = d[65:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive64(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic ext, input logic [4:0] tag);
    bus64.in_valid = v;
    bus64.in_a     = a;
    bus64.in_b     = b;
    bus64.in_ext   = ext;
    bus64.in_tag   = tag;
  endtask

  task automatic chk_out64(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic ext, input logic [4:0] tag);
    ref_t r;
    r = ref_cmp(a, b, ext, 64);
    chk({name, ".valid"}, 128'(bus64.out_valid), 128'(1));
    chk({name, ".lt"},    128'(bus64.out_lt),    128'(r.lt));
    chk({name, ".eq"},    128'(bus64.out_eq),    128'(r.eq));
    chk({name, ".gt"},    128'(bus64.out_gt),    128'(r.gt));
    chk({name, ".diff"},  128'(bus64.out_diff),  128'(r.diff));
    chk({name, ".tag"},   128'(bus64.out_tag),   128'(tag));
  endtask

  // Issue one op with no backpressure and check it lands exactly two edges later.
  task automatic single64(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic ext, input logic [4:0] tag);
    drive64(1'b1, a, b, ext, tag);
    chk({name, ".in_ready"}, 128'(bus64.in_ready), 128'(1));
    tick();
    drive64(1'b0, '0, '0, 1'b0, '0);
    chk({name, ".early"}, 128'(bus64.out_valid), 128'(0));
    tick();
    chk_out64(name, a, b, ext, tag);
  endtask

  initial begin
    logic [63:0] sa [16];
    logic [63:0] sb [16];
    logic        se [16];
    logic [63:0] ba [3];
    logic [63:0] bb [3];
    exp8_t       q [$];
    exp8_t       e;
    int unsigned cyc;
    logic        m_ov, m_ir, oxf, ixf;

    reset = 1'b1;
    drive64(1'b0, '0, '0, 1'b0, '0);
    bus64.out_ready = 1'b1;
    bus8.in_valid   = 1'b0;
    bus8.in_a       = '0;
    bus8.in_b       = '0;
    bus8.in_ext     = 1'b0;
    bus8.in_tag     = '0;
    bus8.out_ready  = 1'b1;

    @(posedge clk);
    #1;
    chk("rst.valid",    128'(bus64.out_valid), 128'(0));
    chk("rst.lt",       128'(bus64.out_lt),    128'(0));
    chk("rst.eq",       128'(bus64.out_eq),    128'(0));
    chk("rst.gt",       128'(bus64.out_gt),    128'(0));
    chk("rst.diff",     128'(bus64.out_diff),  128'(0));
    chk("rst.tag",      128'(bus64.out_tag),   128'(0));
    chk("rst.in_ready", 128'(bus64.in_ready),  128'(1));
    chk("rst.valid8",   128'(bus8.out_valid),  128'(0));
    #4 reset = 1'b0;
    tick();

    single64("uns", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 5'd1);
    chk("uns.gt_k",   128'(bus64.out_gt),   128'(1));
    chk("uns.diff_k", 128'(bus64.out_diff), 128'(66'h0_FFFF_FFFF_FFFF_FFFE));
    single64("sgn", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 5'd2);
    chk("sgn.lt_k",   128'(bus64.out_lt),   128'(1));
    chk("sgn.diff_k", 128'(bus64.out_diff), 128'(66'h3_FFFF_FFFF_FFFF_FFFE));
    single64("bnd", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 5'd3);
    chk("bnd.lt_k",   128'(bus64.out_lt),   128'(1));
    single64("beq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 5'd4);
    chk("beq.eq_k",   128'(bus64.out_eq),   128'(1));
    chk("beq.diff_k", 128'(bus64.out_diff), 128'(0));
    tick();
    chk("idle.valid", 128'(bus64.out_valid), 128'(0));

    // Back-to-back stream: results on consecutive cycles in tag order.
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        sa[i] = {$urandom, $urandom};
        sb[i] = (i == 5) ? sa[i] : {$urandom, $urandom};
        se[i] = 1'($urandom_range(0, 1));
        drive64(1'b1, sa[i], sb[i], se[i], 5'(i));
        chk("stream.in_ready", 128'(bus64.in_ready), 128'(1));
      end else begin
        drive64(1'b0, '0, '0, 1'b0, '0);
      end
      if (i >= 2) chk_out64("stream", sa[i-2], sb[i-2], se[i-2], 5'(i - 2));
      else        chk("stream.fill", 128'(bus64.out_valid), 128'(0));
      tick();
    end
    chk("stream.drain", 128'(bus64.out_valid), 128'(0));

    // Backpressure: two accepted, third refused until out_ready rises.
    for (int i = 0; i < 3; i++) begin
      ba[i] = {$urandom, $urandom};
      bb[i] = {$urandom, $urandom};
    end
    bus64.out_ready = 1'b0;
    drive64(1'b1, ba[0], bb[0], 1'b1, 5'd20);
    chk("bp.rdy0", 128'(bus64.in_ready), 128'(1));
    tick();
    drive64(1'b1, ba[1], bb[1], 1'b0, 5'd21);
    chk("bp.rdy1", 128'(bus64.in_ready), 128'(1));
    chk("bp.nov",  128'(bus64.out_valid), 128'(0));
    tick();
    drive64(1'b1, ba[2], bb[2], 1'b1, 5'd22);
    for (int k = 0; k < 3; k++) begin
      chk("bp.full", 128'(bus64.in_ready), 128'(0));
      chk_out64("bp.hold", ba[0], bb[0], 1'b1, 5'd20);
      if (k < 2) tick();
    end
    bus64.out_ready = 1'b1;
    #1;
    chk("bp.release", 128'(bus64.in_ready), 128'(1));
    tick();
    drive64(1'b0, '0, '0, 1'b0, '0);
    chk_out64("bp.o1", ba[1], bb[1], 1'b0, 5'd21);
    tick();
    chk_out64("bp.o2", ba[2], bb[2], 1'b1, 5'd22);
    tick();
    chk("bp.empty", 128'(bus64.out_valid), 128'(0));

    // Asynchronous reset with two entries in flight.
    drive64(1'b1, 64'd5, 64'd9, 1'b0, 5'd9);
    tick();
    drive64(1'b1, 64'd9, 64'd5, 1'b0, 5'd10);
    tick();
    drive64(1'b0, '0, '0, 1'b0, '0);
    chk("mid.valid", 128'(bus64.out_valid), 128'(1));
    #2 reset = 1'b1;
    #1;
    chk("mid.rst_valid", 128'(bus64.out_valid), 128'(0));
    chk("mid.rst_tag",   128'(bus64.out_tag),   128'(0));
    chk("mid.rst_ready", 128'(bus64.in_ready),  128'(1));
    #1 reset = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("mid.gone", 128'(bus64.out_valid), 128'(0));
      tick();
    end
    single64("post", 64'd77, 64'd78, 1'b1, 5'd11);
    tick();

    // Randomized W=8 run: model tracks occupancy and arrival order only.
    cyc = 0;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        bus8.in_valid  = ($urandom_range(0, 3) != 0);
        bus8.out_ready = ($urandom_range(0, 9) < (((c % 100) < 50) ? 8 : 3));
      end else begin
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
      end
      bus8.in_a   = 8'($urandom);
      bus8.in_b   = ($urandom_range(0, 7) == 0) ? bus8.in_a : 8'($urandom);
      bus8.in_ext = 1'($urandom_range(0, 1));
      bus8.in_tag = 3'($urandom);
      #1;
      m_ov = (q.size() > 0) && (q[0].acc < cyc);
      m_ir = (q.size() < 2) || bus8.out_ready;
      chk("rnd.valid",    128'(bus8.out_valid), 128'(m_ov));
      chk("rnd.in_ready", 128'(bus8.in_ready),  128'(m_ir));
      if (m_ov) begin
        chk("rnd.lt",   128'(bus8.out_lt),   128'(q[0].r.lt));
        chk("rnd.eq",   128'(bus8.out_eq),   128'(q[0].r.eq));
        chk("rnd.gt",   128'(bus8.out_gt),   128'(q[0].r.gt));
        chk("rnd.diff", 128'(bus8.out_diff), 128'(q[0].r.diff));
        chk("rnd.tag",  128'(bus8.out_tag),  128'(q[0].tag));
      end
      if (bus8.out_valid) begin
        chk("rnd.onehot", 128'($countones({bus8.out_lt, bus8.out_eq, bus8.out_gt})), 128'(1));
      end
      oxf   = m_ov && bus8.out_ready;
      ixf   = bus8.in_valid && m_ir;
      e.r   = ref_cmp({56'b0, bus8.in_a}, {56'b0, bus8.in_b}, bus8.in_ext, 8);
      e.tag = bus8.in_tag;
      @(posedge clk);
      cyc++;
      e.acc = cyc;
      if (oxf) void'(q.pop_front());
      if (ixf) q.push_back(e);
      #1;
    end
    chk("rnd.end_valid", 128'(bus8.out_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comp_pipe_compare.md
# comp_pipe_compare

Parametrised, two-stage pipelined magnitude comparator for the ALU compare path. Extends two W-bit operands to W+1 bits, either sign- or zero-extended per operation. Registers the extended operands, then produces lt/eq/gt flags and the extended difference. Uses a valid/ready handshake so the ALU issue logic and writeback can stall it independently.

## Interface
- W, 64, operand width in bits (≥2)
- TAG_W, 5, width of the sideband tag (destination register index) carried alongside each operation
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  block accepts the operation this cycle
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_ext  input  1  1 = signed compare (sign-extend), 0 = unsigned (zero-extend)
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts result this cycle
- out_lt, out_eq, out_gt  output  1 each  A<B, A==B, A>B under the selected mode; exactly one is set when out_valid
- out_diff  output  W+2  extended difference A_x − B_x
- out_tag  output  TAG_W  tag of the operation

## Operation
- Extension, per operand X: X_x = {in_ext & X[W-1], X}, W+1 bits.
- Stage 1 (S1) registers a_x, b_x, tag and s1_valid on each accepted input.
- Stage 2 (S2) computes diff = {a_x[W], a_x} − {b_x[W], b_x}, modulo 2^(W+2); this never overflows.
  - lt = diff[W+1]
  - eq = (a_x == b_x)
  - gt = ~lt & ~eq
- S2 registers these with the tag and s2_valid. All outputs come directly from S2 registers.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv, which is combinational from out_ready. No skid buffer.
- Hold rules:
  - While out_valid & ~out_ready, every out_* stays stable.
  - While S1 holds a stalled entry, S1 contents are unchanged.
- Simultaneous events: S2 drains while S1 moves into S2 while a new input loads S1, all in the same cycle. This gives full throughput.
- Inputs are sampled only on a transfer. in_a, in_b, in_ext and in_tag are don't-care when in_valid=0.

## Timing
- Reset (asynchronous, on assertion): s1_valid=0, s2_valid=0, all data registers 0. Resulting outputs: out_valid=0, out_lt=out_eq=out_gt=0, out_diff=0, out_tag=0, in_ready=1.
- Reset mid-operation discards all in-flight entries; no result for them ever appears.
- Latency: input accepted at edge n gives out_valid=1 after edge n+2, with no backpressure.
- Throughput: one operation per cycle while out_ready=1.
- Capacity: 2 in flight. With out_ready held 0, two inputs are accepted, then in_ready=0 until the result drains.
- Results emerge in acceptance order. Tags are never reordered or duplicated.

## Structure
- Shared ALU package holds:
  - CMP_W_DEFAULT=64
  - CMP_TAG_W_DEFAULT=5
  - cmp_flags_t, a 3-bit packed {lt, eq, gt}, reused by branch-resolve logic
- Sub-module comp_extend_w (parameter W): combinational {ext & din[W-1], din} → W+1 bits, instantiated for A and B.
- Top level holds both pipeline stages and the handshake logic.

## Test plan
- Unsigned vs signed, W=64, out_ready=1:
  - A=0xFFFF_FFFF_FFFF_FFFF, B=1, ext=0 → gt=1, out_diff=0x0_FFFF_FFFF_FFFF_FFFE, 2 cycles after acceptance.
  - Same operands, ext=1 → lt=1, out_diff=0x3_FFFF_FFFF_FFFF_FFFE.
- Boundary, ext=1: A=0x8000_0000_0000_0000, B=0x7FFF_FFFF_FFFF_FFFF → lt=1 (no overflow). A=B=0x8000_0000_0000_0000 → eq=1, diff=0.
- Streaming: 16 back-to-back ops with tags 0..15, out_ready=1 → 16 results on consecutive cycles in tag order. in_ready stays 1.
- Backpressure: out_ready=0, 3 ops offered → 2 accepted, then in_ready=0 and out_* stable. Raise out_ready → third accepted the same cycle; results in order, none dropped.
- Reset mid-flight: 2 ops in flight, pulse reset between clock edges → out_valid=0 immediately, no result for those ops afterwards. The next op appears 2 cycles after its acceptance.
- Random W=8, TAG_W=3 with random valid/ready → flags match a reference model for every op, and exactly one flag is set on every valid cycle.
